// File: rtl/cmos_cam_gen.sv
// cmos_cam_gen -- CMOS camera timing generator.
//
// Produces VSYNC/HREF framing for a configurable resolution, with the byte
// address of the current pixel inside a BMP-style frame buffer (header
// offset, rows padded to 4 bytes, optional bottom-up row order).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low
//   en           run request, sampled in IDLE and at each frame end
//   frame_limit  frames to emit after start (0 = free-run)
//   cmos_vsync   frame sync, level VSYNC_POL during the VSYNC lines
//   cmos_href    high on every active beat
//   cmos_beat    beat phase within a pixel (BYTE_MODE=1 only)
//   cmos_index   buffer byte address of the current pixel's first byte
//   line_cnt     active line number in emission order
//   frame_cnt    frames completed since start (saturating)
//   frame_done   one-cycle pulse on the last cycle of each frame
//   busy         high whenever not IDLE
module cmos_cam_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int H_BLANK    = 160,
  parameter int V_SYNC     = 4,
  parameter int V_BACK     = 16,
  parameter int V_FRONT    = 4,
  parameter int BPP        = 3,
  parameter int HDR_OFFSET = 54,
  parameter int BOTTOM_UP  = 1,
  parameter int BYTE_MODE  = 0,
  parameter int VSYNC_POL  = 1,
  parameter int INDEX_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [15:0]        frame_limit,
  output logic               cmos_vsync,
  output logic               cmos_href,
  output logic               cmos_beat,
  output logic [INDEX_W-1:0] cmos_index,
  output logic [15:0]        line_cnt,
  output logic [15:0]        frame_cnt,
  output logic               frame_done,
  output logic               busy
);

  localparam int HREF_LEN = H_ACTIVE * (1 + BYTE_MODE);
  localparam int LINE_LEN = HREF_LEN + H_BLANK;
  localparam int STRIDE   = ((H_ACTIVE * BPP + 3) / 4) * 4;
  localparam longint MAX_INDEX = longint'(HDR_OFFSET)
                               + longint'(V_ACTIVE - 1) * longint'(STRIDE)
                               + longint'(H_ACTIVE - 1) * longint'(BPP);

  localparam logic [15:0] H_LAST   = 16'(LINE_LEN - 1);
  localparam logic [15:0] HREF_END = 16'(HREF_LEN);
  localparam logic [15:0] VS_LAST  = 16'(V_SYNC - 1);
  localparam logic [15:0] VB_LAST  = 16'(V_BACK - 1);
  localparam logic [15:0] VA_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VF_LAST  = 16'(V_FRONT - 1);
  localparam logic        POL      = (VSYNC_POL != 0);

  localparam logic [INDEX_W-1:0] IDX_HDR    = INDEX_W'(HDR_OFFSET);
  localparam logic [INDEX_W-1:0] IDX_STRIDE = INDEX_W'(STRIDE);
  localparam logic [INDEX_W-1:0] IDX_BPP    = INDEX_W'(BPP);

  if (INDEX_W < 63 && MAX_INDEX >= (longint'(1) << INDEX_W)) begin : g_index_too_narrow
    $error("cmos_cam_gen: INDEX_W too narrow for largest pixel index");
  end
  if (H_BLANK < 1 || V_SYNC < 1 || BPP < 1 || BPP > 4 || LINE_LEN > 65536) begin : g_bad_params
    $error("cmos_cam_gen: illegal timing parameters");
  end

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  // The frame's final cycle lives in VFRONT, or in the last active line
  // when there is no front porch.
  localparam state_t      LAST_STATE = (V_FRONT > 0) ? S_VFRONT : S_ACTIVE;
  localparam logic [15:0] LAST_V     = (V_FRONT > 0) ? VF_LAST : VA_LAST;

  state_t      state, nxt_state;
  logic [15:0] v_cnt, h_cnt, nxt_v, nxt_h;
  logic        stop, frame_end, nxt_last, nxt_href, nxt_beat;
  logic [15:0] row16, col16;
  logic [INDEX_W-1:0] nxt_index;

  function automatic logic [15:0] phase_last(input state_t s);
    case (s)
      S_VSYNC:  return VS_LAST;
      S_VBACK:  return VB_LAST;
      S_ACTIVE: return VA_LAST;
      default:  return VF_LAST;
    endcase
  endfunction

  // frame_cnt already holds the incremented count during the final cycle,
  // so reaching the limit is a plain equality here.
  assign stop = !en || (frame_limit != 16'd0 && frame_cnt == frame_limit);

  // Next raster position: (state, line within phase, cycle within line).
  always_comb begin
    nxt_state = state;
    nxt_v     = v_cnt;
    nxt_h     = h_cnt;
    frame_end = 1'b0;
    if (state == S_IDLE) begin
      if (en) begin
        nxt_state = S_VSYNC;
        nxt_v     = '0;
        nxt_h     = '0;
      end
    end else if (h_cnt != H_LAST) begin
      nxt_h = h_cnt + 16'd1;
    end else begin
      nxt_h = '0;
      if (v_cnt != phase_last(state)) begin
        nxt_v = v_cnt + 16'd1;
      end else begin
        nxt_v = '0;
        case (state)
          S_VSYNC:  nxt_state = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
          S_VBACK:  nxt_state = S_ACTIVE;
          S_ACTIVE: if (V_FRONT > 0) nxt_state = S_VFRONT;
                    else frame_end = 1'b1;
          default:  frame_end = 1'b1;
        endcase
        if (frame_end) nxt_state = stop ? S_IDLE : S_VSYNC;
      end
    end
  end

  // Outputs are registered from the next position so they line up with it.
  always_comb begin
    nxt_last  = (nxt_state == LAST_STATE) && (nxt_v == LAST_V) && (nxt_h == H_LAST);
    nxt_href  = (nxt_state == S_ACTIVE) && (nxt_h < HREF_END);
    nxt_beat  = (BYTE_MODE != 0) && nxt_href && nxt_h[0];
    col16     = (BYTE_MODE != 0) ? {1'b0, nxt_h[15:1]} : nxt_h;
    row16     = (BOTTOM_UP != 0) ? (VA_LAST - nxt_v) : nxt_v;
    nxt_index = IDX_HDR + INDEX_W'(row16) * IDX_STRIDE + INDEX_W'(col16) * IDX_BPP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      v_cnt      <= '0;
      h_cnt      <= '0;
      cmos_vsync <= ~POL;
      cmos_href  <= 1'b0;
      cmos_beat  <= 1'b0;
      cmos_index <= IDX_HDR;
      line_cnt   <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt_state;
      v_cnt      <= nxt_v;
      h_cnt      <= nxt_h;
      cmos_vsync <= (nxt_state == S_VSYNC) ? POL : ~POL;
      cmos_href  <= nxt_href;
      cmos_beat  <= nxt_beat;
      if (nxt_href) cmos_index <= nxt_index;
      if (nxt_state == S_VSYNC)
        line_cnt <= '0;
      else if (nxt_state == S_ACTIVE && nxt_h == 16'd0)
        line_cnt <= nxt_v;
      frame_done <= nxt_last;
      if (state == S_IDLE && en)
        frame_cnt <= '0;
      else if (nxt_last && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
      busy <= (nxt_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_cmos_cam_gen.sv
// Testbench for cmos_cam_gen: three small configurations run side by side
// (bottom-up, top-down with odd width, byte mode with inverted vsync),
// compared every cycle against a raster-arithmetic reference model.
module tb_cmos_cam_gen;
  localparam int N = 3;
  localparam int HA  [N] = '{4, 5, 4};
  localparam int BU  [N] = '{1, 0, 1};
  localparam int BM  [N] = '{0, 0, 1};
  localparam int POL [N] = '{1, 1, 0};
  localparam int VA = 3, HB = 2, VSN = 2, VBK = 1, VFR = 1, BPPV = 3, HDR = 54;

  typedef struct packed {
    logic        vs;
    logic        hr;
    logic        bt;
    logic [31:0] ix;
    logic [15:0] ln;
    logic [15:0] fc;
    logic        fd;
    logic        bz;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [15:0] frame_limit;
  logic        vs [N], hr [N], bt [N], fd [N], bz [N];
  logic [31:0] ix [N];
  logic [15:0] lc [N], fcn [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    cmos_cam_gen #(
      .H_ACTIVE(HA[g]), .V_ACTIVE(VA), .H_BLANK(HB), .V_SYNC(VSN), .V_BACK(VBK),
      .V_FRONT(VFR), .BPP(BPPV), .HDR_OFFSET(HDR), .BOTTOM_UP(BU[g]),
      .BYTE_MODE(BM[g]), .VSYNC_POL(POL[g]), .INDEX_W(32)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .frame_limit(frame_limit),
      .cmos_vsync(vs[g]), .cmos_href(hr[g]), .cmos_beat(bt[g]), .cmos_index(ix[g]),
      .line_cnt(lc[g]), .frame_cnt(fcn[g]), .frame_done(fd[g]), .busy(bz[g])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: running flag, cycle position inside the frame,
  // frames completed, and held values of index/line between active beats.
  bit    m_run [N];
  int    m_pos [N], m_fc [N], m_ix [N], m_ln [N];
  snap_t m_exp [N];

  function automatic int frame_len(int d);
    return (HA[d] * (1 + BM[d]) + HB) * (VSN + VBK + VA + VFR);
  endfunction

  function automatic void compute(int d);
    snap_t s;
    int ll, lin, h, al, row, stride;
    ll     = HA[d] * (1 + BM[d]) + HB;
    stride = ((HA[d] * BPPV + 3) / 4) * 4;
    s.vs = (POL[d] == 0);
    s.hr = 1'b0;
    s.bt = 1'b0;
    s.ix = 32'(m_ix[d]);
    s.ln = 16'(m_ln[d]);
    s.fc = 16'(m_fc[d]);
    s.fd = 1'b0;
    s.bz = m_run[d];
    if (m_run[d]) begin
      lin = m_pos[d] / ll;
      h   = m_pos[d] % ll;
      al  = lin - (VSN + VBK);
      if (lin < VSN) s.vs = (POL[d] != 0);
      if (al >= 0 && al < VA && h < HA[d] * (1 + BM[d])) begin
        row  = (BU[d] != 0) ? VA - 1 - al : al;
        s.hr = 1'b1;
        s.bt = (BM[d] != 0) && (h % 2 == 1);
        s.ix = 32'(HDR + row * stride + (h / (1 + BM[d])) * BPPV);
      end
      s.ln = 16'((lin < VSN + VBK) ? 0 : ((al < VA) ? al : VA - 1));
      s.fd = (m_pos[d] == frame_len(d) - 1);
    end
    m_ix[d]  = int'(s.ix);
    m_ln[d]  = int'(s.ln);
    m_exp[d] = s;
  endfunction

  function automatic void model_step(int d, logic e, logic r, logic [15:0] lim);
    if (!r) begin
      m_run[d] = 0; m_pos[d] = 0; m_fc[d] = 0; m_ix[d] = HDR; m_ln[d] = 0;
    end else if (!m_run[d]) begin
      if (e) begin m_run[d] = 1; m_pos[d] = 0; m_fc[d] = 0; end
    end else if (m_pos[d] == frame_len(d) - 1) begin
      if (!e || (lim != 16'd0 && m_fc[d] == int'(lim))) m_run[d] = 0;
      else m_pos[d] = 0;
    end else begin
      m_pos[d]++;
      if (m_pos[d] == frame_len(d) - 1 && m_fc[d] < 65535) m_fc[d]++;
    end
    compute(d);
  endfunction

  function automatic snap_t obs(int d);
    snap_t s;
    s.vs = vs[d]; s.hr = hr[d]; s.bt = bt[d]; s.ix = ix[d];
    s.ln = lc[d]; s.fc = fcn[d]; s.fd = fd[d]; s.bz = bz[d];
    return s;
  endfunction

  // One clock: the model sees the inputs the DUT samples at this edge.
  task automatic tick();
    logic e, r;
    logic [15:0] l;
    e = en; r = rst_n; l = frame_limit;
    @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) model_step(d, e, r, l);
  endtask

  task automatic test_reset();
    snap_t got;
    rst_n = 1'b0; en = 1'b1; frame_limit = 16'd1;
    repeat (3) tick();
    for (int d = 0; d < N; d++) begin
      got = obs(d);
      n_checks++;
      if (got !== m_exp[d]) $display("FAIL reset dut%0d got=%h exp=%h", d, got, m_exp[d]);
      else n_pass++;
    end
    n_checks++;
    if (ix[0] !== 32'd54 || vs[0] !== 1'b0 || bz[0] !== 1'b0 || hr[0] !== 1'b0)
      $display("FAIL reset_literal got ix=%0d vs=%b busy=%b href=%b exp ix=54 vs=0 busy=0 href=0",
               ix[0], vs[0], bz[0], hr[0]);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    snap_t got;
    int q0[$], q1[$], q2[$], b2[$];
    int exp0 [12];
    int vs_cnt, vs_first, fd0_t, fd0_n, fd2_t, busy43;
    exp0 = '{78, 81, 84, 87, 66, 69, 72, 75, 54, 57, 60, 63};
    vs_cnt = 0; vs_first = -1; fd0_t = -1; fd0_n = 0; fd2_t = -1; busy43 = -1;
    rst_n = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      tick();
      for (int d = 0; d < N; d++) begin
        got = obs(d);
        n_checks++;
        if (got !== m_exp[d]) $display("FAIL frame1 dut%0d t=%0d got=%h exp=%h", d, t, got, m_exp[d]);
        else n_pass++;
      end
      if (hr[0]) q0.push_back(int'(ix[0]));
      if (hr[1]) q1.push_back(int'(ix[1]));
      if (hr[2]) begin q2.push_back(int'(ix[2])); b2.push_back(int'(bt[2])); end
      if (vs[0]) begin vs_cnt++; if (vs_first < 0) vs_first = t; end
      if (fd[0]) begin fd0_n++; fd0_t = t; end
      if (fd[2]) fd2_t = t;
      if (t == 43) begin busy43 = int'(bz[0]); en = 1'b0; end
    end
    n_checks++;
    if (vs_first != 1 || vs_cnt != 12) $display("FAIL vsync_window got first=%0d len=%0d exp first=1 len=12", vs_first, vs_cnt);
    else n_pass++;
    n_checks++;
    if (q0.size() != 12) $display("FAIL beats_dut0 got=%0d exp=12", q0.size());
    else begin
      n_pass++;
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (q0[i] != exp0[i]) $display("FAIL index_bu beat%0d got=%0d exp=%0d", i, q0[i], exp0[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (fd0_n != 1 || fd0_t != 42) $display("FAIL frame_done_dut0 got n=%0d t=%0d exp n=1 t=42", fd0_n, fd0_t);
    else n_pass++;
    n_checks++;
    if (busy43 != 0 || fcn[0] !== 16'd1) $display("FAIL limit_stop got busy=%0d fc=%0d exp busy=0 fc=1", busy43, fcn[0]);
    else n_pass++;
    n_checks++;
    if (q1.size() != 15 || q1[5] != 70) $display("FAIL topdown got beats=%0d line1=%0d exp beats=15 line1=70",
                                                 q1.size(), (q1.size() > 5) ? q1[5] : -1);
    else n_pass++;
    n_checks++;
    if (q2.size() != 24 || q2[0] != 78 || q2[1] != 78 || q2[2] != 81 || q2[3] != 81 ||
        b2[0] != 0 || b2[1] != 1 || b2[2] != 0 || b2[3] != 1 || fd2_t != 70)
      $display("FAIL byte_mode got beats=%0d done_t=%0d exp beats=24 pairs 78,78,81,81 beat 0,1,0,1 done_t=70",
               q2.size(), fd2_t);
    else n_pass++;
  endtask

  task automatic test_free_run();
    snap_t got;
    rst_n = 1'b0; en = 1'b0; frame_limit = 16'd0;
    repeat (2) tick();
    rst_n = 1'b1; en = 1'b1;
    for (int t = 1; t <= 150; t++) begin
      tick();
      for (int d = 0; d < N; d++) begin
        got = obs(d);
        n_checks++;
        if (got !== m_exp[d]) $display("FAIL freerun dut%0d t=%0d got=%h exp=%h", d, t, got, m_exp[d]);
        else n_pass++;
      end
      if (t == 126) begin
        n_checks++;
        if (fd[0] !== 1'b1 || fcn[0] !== 16'd3) $display("FAIL freerun_end got fd=%b fc=%0d exp fd=1 fc=3", fd[0], fcn[0]);
        else n_pass++;
      end
      if (t == 127) begin
        n_checks++;
        if (bz[0] !== 1'b0 || fcn[0] !== 16'd3) $display("FAIL freerun_idle got busy=%b fc=%0d exp busy=0 fc=3", bz[0], fcn[0]);
        else n_pass++;
      end
      if (t == 100) en = 1'b0;
    end
  endtask

  task automatic test_reset_midframe();
    snap_t got;
    rst_n = 1'b0; en = 1'b0; frame_limit = 16'd0;
    tick();
    rst_n = 1'b1; en = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (hr[0] !== 1'b1) $display("FAIL midframe_active got href=%b exp=1", hr[0]);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    for (int d = 0; d < N; d++) begin
      got = obs(d);
      n_checks++;
      if (got !== m_exp[d] || fd[d] !== 1'b0 || ix[d] !== 32'd54 || bz[d] !== 1'b0)
        $display("FAIL midframe_reset dut%0d got=%h exp=%h", d, got, m_exp[d]);
      else n_pass++;
    end
    rst_n = 1'b1; en = 1'b0;
    tick();
    n_checks++;
    if (bz[0] !== 1'b0 || fd[0] !== 1'b0) $display("FAIL post_reset_idle got busy=%b fd=%b exp busy=0 fd=0", bz[0], fd[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    snap_t got;
    for (int it = 0; it < 4; it++) begin
      rst_n = 1'b0; en = 1'b0;
      tick();
      rst_n = 1'b1;
      frame_limit = 16'($urandom_range(0, 3));
      for (int t = 1; t <= 300; t++) begin
        en = ($urandom_range(0, 9) < 8);
        tick();
        for (int d = 0; d < N; d++) begin
          got = obs(d);
          n_checks++;
          if (got !== m_exp[d]) $display("FAIL random it%0d dut%0d t=%0d got=%h exp=%h", it, d, t, got, m_exp[d]);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; frame_limit = 16'd0;
    for (int d = 0; d < N; d++) begin
      m_run[d] = 0; m_pos[d] = 0; m_fc[d] = 0; m_ix[d] = HDR; m_ln[d] = 0;
      compute(d);
    end
    test_reset();
    test_single_frame();
    test_free_run();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
